// File: rtl/alarm_ctrl.sv
// alarm_ctrl: alarm controller for the BCD clock.
//   Holds a user-editable HH:MM alarm, compares it against the running time
//   and sequences the buzzer through ring, snooze and auto-off phases.
//   While set_alarm is high the alarm digits can be edited with the debounced
//   switch_select/increment pulses. A one-hot sel output and a blink strobe
//   drive the display.
// Ports:
//   clk, resetn             clock, asynchronous active-low reset
//   sec_tick                one-cycle 1 Hz strobe
//   hrT..secU               current time, BCD digits
//   alarm_enable            level, alarm armed when high
//   set_alarm               level, edit mode while high
//   switch_select/increment one-cycle pulses, edit controls
//   snooze/dismiss          one-cycle pulses, ring controls
//   alm_hrT..alm_minU       stored alarm, BCD digits
//   sel                     one-hot edit digit (bit0 minU .. bit3 hrT), 0 outside SET
//   blink                   toggles on sec_tick while editing
//   buzzer/snoozing         high in RING / SNOOZE respectively
module alarm_ctrl #(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300,
  parameter int CNT_W          = 9
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       sec_tick,
  input  logic [3:0] hrT,
  input  logic [3:0] hrU,
  input  logic [3:0] minT,
  input  logic [3:0] minU,
  input  logic [3:0] secT,
  input  logic [3:0] secU,
  input  logic       alarm_enable,
  input  logic       set_alarm,
  input  logic       switch_select,
  input  logic       increment,
  input  logic       snooze,
  input  logic       dismiss,
  output logic [3:0] alm_hrT,
  output logic [3:0] alm_hrU,
  output logic [3:0] alm_minT,
  output logic [3:0] alm_minU,
  output logic [3:0] sel,
  output logic       blink,
  output logic       buzzer,
  output logic       snoozing
);

  typedef enum logic [1:0] {IDLE, SET, RING, SNOOZE} stateType;

  localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_SECONDS - 1);
  localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_SECONDS - 1);

  stateType         state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [3:0]       selNext;
  logic             blinkNext;
  logic [3:0]       almHrTNext, almHrUNext, almMinTNext, almMinUNext;
  logic [3:0]       hrTInc;
  logic             eq, eqD, fire;

  // Match is exact on the top of the minute; the registered copy turns it
  // into a one-shot so a held matching time rings only once.
  assign eq = (hrT == alm_hrT) && (hrU == alm_hrU) && (minT == alm_minT) &&
              (minU == alm_minU) && (secT == 4'd0) && (secU == 4'd0);
  assign fire = eq && !eqD && alarm_enable && (state == IDLE);

  assign hrTInc = (alm_hrT == 4'd2) ? 4'd0 : alm_hrT + 4'd1;

  assign buzzer   = (state == RING);
  assign snoozing = (state == SNOOZE);

  always_comb begin
    // NOTE: every signal gets its default first so no path leaves a latch.
    stateNext   = state;
    cntNext     = cnt;
    selNext     = sel;
    blinkNext   = blink;
    almHrTNext  = alm_hrT;
    almHrUNext  = alm_hrU;
    almMinTNext = alm_minT;
    almMinUNext = alm_minU;

    unique case (state)
      IDLE: begin
        if (set_alarm) begin
          stateNext = SET;
          selNext   = 4'b0001;
          blinkNext = 1'b0;
        end else if (fire) begin
          stateNext = RING;
          cntNext   = '0;
        end
      end

      SET: begin
        if (!set_alarm) begin
          stateNext = IDLE;
          selNext   = 4'b0000;
          blinkNext = 1'b0;
        end else begin
          // Increment acts on the digit selected before any rotate this cycle.
          if (increment) begin
            if (sel[0]) begin
              almMinUNext = (alm_minU == 4'd9) ? 4'd0 : alm_minU + 4'd1;
            end else if (sel[1]) begin
              almMinTNext = (alm_minT == 4'd5) ? 4'd0 : alm_minT + 4'd1;
            end else if (sel[2]) begin
              if (alm_hrT == 4'd2) almHrUNext = (alm_hrU >= 4'd3) ? 4'd0 : alm_hrU + 4'd1;
              else                 almHrUNext = (alm_hrU >= 4'd9) ? 4'd0 : alm_hrU + 4'd1;
            end else if (sel[3]) begin
              almHrTNext = hrTInc;
              // Moving into the 20s must not leave an illegal 24..29 hour.
              if (hrTInc == 4'd2 && alm_hrU > 4'd3) almHrUNext = 4'd0;
            end
          end
          if (switch_select) selNext = {sel[2:0], sel[3]};
          blinkNext = blink ^ sec_tick;
        end
      end

      RING: begin
        if (set_alarm) begin
          stateNext = SET;
          selNext   = 4'b0001;
          blinkNext = 1'b0;
        end else if (dismiss || !alarm_enable) begin
          stateNext = IDLE;
        end else if (snooze) begin
          stateNext = SNOOZE;
          cntNext   = '0;
        end else if (sec_tick) begin
          if (cnt == RING_LAST) stateNext = IDLE;
          else                  cntNext   = cnt + 1'b1;
        end
      end

      SNOOZE: begin
        if (set_alarm) begin
          stateNext = SET;
          selNext   = 4'b0001;
          blinkNext = 1'b0;
        end else if (dismiss || !alarm_enable) begin
          stateNext = IDLE;
        end else if (sec_tick) begin
          if (cnt == SNOOZE_LAST) begin
            stateNext = RING;
            cntNext   = '0;
          end else begin
            cntNext = cnt + 1'b1;
          end
        end
      end

      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= '0;
      sel      <= 4'b0000;
      blink    <= 1'b0;
      alm_hrT  <= 4'd0;
      alm_hrU  <= 4'd7;
      alm_minT <= 4'd0;
      alm_minU <= 4'd0;
      eqD      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state    <= stateNext;
      cnt      <= cntNext;
      sel      <= selNext;
      blink    <= blinkNext;
      alm_hrT  <= almHrTNext;
      alm_hrU  <= almHrUNext;
      alm_minT <= almMinTNext;
      alm_minU <= almMinUNext;
      eqD      <= eq;
    end
  end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl with short ring/snooze durations.
// A behavioural model (alarm kept as integer hour/minute, phases as plain
// integers with elapsed-tick counters) predicts every output each cycle;
// directed literal checks pin key points of the test plan.
module tb_alarm_ctrl;

  localparam int RING_S   = 4;
  localparam int SNOOZE_S = 3;

  logic       clk = 1'b0;
  logic       resetn;
  logic       sec_tick, alarm_enable, set_alarm, switch_select, increment, snooze, dismiss;
  logic [3:0] hrT, hrU, minT, minU, secT, secU;
  logic [3:0] alm_hrT, alm_hrU, alm_minT, alm_minU, sel;
  logic       blink, buzzer, snoozing;

  int checks = 0;
  int errors = 0;
  bit checkEn = 0;

  alarm_ctrl #(.RING_SECONDS(RING_S), .SNOOZE_SECONDS(SNOOZE_S), .CNT_W(9)) dut (
    .clk(clk), .resetn(resetn), .sec_tick(sec_tick),
    .hrT(hrT), .hrU(hrU), .minT(minT), .minU(minU), .secT(secT), .secU(secU),
    .alarm_enable(alarm_enable), .set_alarm(set_alarm),
    .switch_select(switch_select), .increment(increment),
    .snooze(snooze), .dismiss(dismiss),
    .alm_hrT(alm_hrT), .alm_hrU(alm_hrU), .alm_minT(alm_minT), .alm_minU(alm_minU),
    .sel(sel), .blink(blink), .buzzer(buzzer), .snoozing(snoozing)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 editing, 2 ringing, 3 snoozing
  int aHr, aMin, phase, digit, ticks;
  bit blinkM, prevMatch;

  function automatic logic [15:0] alarmDigits();
    return {4'(aHr / 10), 4'(aHr % 10), 4'(aMin / 10), 4'(aMin % 10)};
  endfunction

  task automatic bumpDigit();
    int t, u;
    case (digit)
      0: begin u = aMin % 10; u = (u == 9) ? 0 : u + 1; aMin = (aMin / 10) * 10 + u; end
      1: begin t = aMin / 10; t = (t == 5) ? 0 : t + 1; aMin = t * 10 + aMin % 10; end
      2: begin
        u = aHr % 10;
        u = (u >= ((aHr / 10 == 2) ? 3 : 9)) ? 0 : u + 1;
        aHr = (aHr / 10) * 10 + u;
      end
      default: begin
        t = aHr / 10; t = (t == 2) ? 0 : t + 1;
        u = aHr % 10;
        if (t == 2 && u > 3) u = 0;
        aHr = t * 10 + u;
      end
    endcase
  endtask

  task automatic enterEdit();
    phase = 1; digit = 0; blinkM = 0;
  endtask

  always @(posedge clk or negedge resetn) begin
    bit matchNow, fireNow;
    if (!resetn) begin
      aHr = 7; aMin = 0; phase = 0; digit = 0; ticks = 0; blinkM = 0; prevMatch = 0;
    end else begin
      matchNow = (hrT == 4'(aHr / 10)) && (hrU == 4'(aHr % 10)) &&
                 (minT == 4'(aMin / 10)) && (minU == 4'(aMin % 10)) &&
                 (secT == 4'd0) && (secU == 4'd0);
      fireNow = matchNow && !prevMatch && alarm_enable;
      case (phase)
        0: if (set_alarm) enterEdit();
           else if (fireNow) begin phase = 2; ticks = 0; end
        1: if (!set_alarm) begin phase = 0; blinkM = 0; end
           else begin
             if (increment) bumpDigit();
             if (switch_select) digit = (digit + 1) % 4;
             if (sec_tick) blinkM = !blinkM;
           end
        2: if (set_alarm) enterEdit();
           else if (dismiss || !alarm_enable) phase = 0;
           else if (snooze) begin phase = 3; ticks = 0; end
           else if (sec_tick) begin ticks++; if (ticks == RING_S) phase = 0; end
        default:
           if (set_alarm) enterEdit();
           else if (dismiss || !alarm_enable) phase = 0;
           else if (sec_tick) begin ticks++; if (ticks == SNOOZE_S) begin phase = 2; ticks = 0; end end
      endcase
      prevMatch = matchNow;
    end
  end

  // Compare process: outputs are all register-derived, so sample mid-cycle.
  always @(negedge clk) begin
    if (checkEn && resetn) begin
      check("m_alarm", {alm_hrT, alm_hrU, alm_minT, alm_minU}, alarmDigits());
      check("m_sel", {12'd0, sel}, (phase == 1) ? 16'(1 << digit) : 16'd0);
      check("m_blink", {15'd0, blink}, {15'd0, (phase == 1) && blinkM});
      check("m_buzzer", {15'd0, buzzer}, {15'd0, phase == 2});
      check("m_snoozing", {15'd0, snoozing}, {15'd0, phase == 3});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    sec_tick = 0; switch_select = 0; increment = 0; snooze = 0; dismiss = 0;
  endtask

  task automatic setTime(input int h, input int m, input int s);
    hrT = 4'(h / 10); hrU = 4'(h % 10);
    minT = 4'(m / 10); minU = 4'(m % 10);
    secT = 4'(s / 10); secU = 4'(s % 10);
  endtask

  task automatic fireAt(input int h, input int m);
    setTime(h, m - 1, 59); step();
    setTime(h, m, 0); step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 0;
    sec_tick = 0; alarm_enable = 0; set_alarm = 0; switch_select = 0;
    increment = 0; snooze = 0; dismiss = 0;
    setTime(0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_alarm", {alm_hrT, alm_hrU, alm_minT, alm_minU}, 16'h0700);
    check("rst_sel", {12'd0, sel}, 16'h0);
    check("rst_outs", {13'd0, blink, buzzer, snoozing}, 16'h0);
    resetn = 1; checkEn = 1;

    // Fire at 07:00:00, dismiss, no refire while the time holds.
    alarm_enable = 1;
    setTime(6, 59, 59); step(); step();
    setTime(7, 0, 0); step();
    check("fire_buzzer", {15'd0, buzzer}, 16'h1);
    repeat (3) step();
    dismiss = 1; step();
    check("dismiss", {15'd0, buzzer}, 16'h0);
    repeat (10) step();
    check("no_refire", {15'd0, buzzer}, 16'h0);

    // Auto-stop after exactly RING_S ticks.
    fireAt(7, 0);
    check("fire2", {15'd0, buzzer}, 16'h1);
    for (int i = 1; i <= 4; i++) begin
      setTime(7, 0, i); sec_tick = 1; step();
      if (i == 3) check("ring_3ticks", {15'd0, buzzer}, 16'h1);
    end
    check("ring_expired", {15'd0, buzzer}, 16'h0);
    setTime(7, 0, 5); sec_tick = 1; step(); step();
    check("no_rering", {15'd0, buzzer}, 16'h0);

    // Snooze, re-ring, snooze beats expiry, dismiss beats snooze.
    fireAt(7, 0);
    snooze = 1; step();
    check("snooze_on", {14'd0, buzzer, snoozing}, 16'h1);
    for (int i = 0; i < 3; i++) begin
      sec_tick = 1; step();
      if (i == 1) check("snooze_hold", {14'd0, buzzer, snoozing}, 16'h1);
    end
    check("re_ring", {14'd0, buzzer, snoozing}, 16'h2);
    repeat (3) begin sec_tick = 1; step(); end
    sec_tick = 1; snooze = 1; step();
    check("snooze_beats_expiry", {14'd0, buzzer, snoozing}, 16'h1);
    repeat (3) begin sec_tick = 1; step(); end
    snooze = 1; dismiss = 1; step();
    check("dismiss_beats_snooze", {14'd0, buzzer, snoozing}, 16'h0);

    // set_alarm beats dismiss while ringing; then edit the alarm.
    fireAt(7, 0);
    set_alarm = 1; dismiss = 1; step();
    check("set_from_ring", {11'd0, buzzer, sel}, 16'h1);
    for (int i = 0; i < 12; i++) begin
      increment = 1; sec_tick = (i % 4 == 0); step();
    end
    check("minU_wrap", {alm_hrT, alm_hrU, alm_minT, alm_minU}, 16'h0702);
    check("blink_3toggles", {15'd0, blink}, 16'h1);
    switch_select = 1; step();
    switch_select = 1; step();
    check("sel_hrU", {12'd0, sel}, 16'h4);
    repeat (5) begin increment = 1; step(); end
    check("hrU_wrap", {alm_hrT, alm_hrU, alm_minT, alm_minU}, 16'h0202);
    switch_select = 1; step();
    repeat (2) begin increment = 1; step(); end
    set_alarm = 0; step();
    check("alarm_2202", {alm_hrT, alm_hrU, alm_minT, alm_minU}, 16'h2202);
    check("sel_cleared", {12'd0, sel}, 16'h0);

    // 19:xx -> hrT increment forces hrU to 0.
    set_alarm = 1; step();
    repeat (3) begin switch_select = 1; step(); end
    repeat (2) begin increment = 1; step(); end
    repeat (3) begin switch_select = 1; step(); end
    repeat (7) begin increment = 1; step(); end
    check("alarm_1902", {alm_hrT, alm_hrU, alm_minT, alm_minU}, 16'h1902);
    switch_select = 1; step();
    increment = 1; step();
    check("hr29_clamp", {alm_hrT, alm_hrU, alm_minT, alm_minU}, 16'h2002);
    increment = 1; switch_select = 1; step();
    check("inc_before_rotate", {alm_hrT, alm_hrU, sel, 4'd0}, 16'h0010);
    setTime(0, 2, 0); step(); step();
    set_alarm = 0; step(); step();
    check("set_exit_nofire", {15'd0, buzzer}, 16'h0);

    // Disabled alarm, editing the time into a match, disable mid-ring.
    alarm_enable = 0;
    fireAt(0, 2);
    check("disabled_nofire", {15'd0, buzzer}, 16'h0);
    alarm_enable = 1; step();
    check("enable_late_nofire", {15'd0, buzzer}, 16'h0);
    fireAt(0, 2);
    check("edit_fire", {15'd0, buzzer}, 16'h1);
    alarm_enable = 0; step();
    check("disable_midring", {15'd0, buzzer}, 16'h0);

    // Reset mid-snooze: outputs return to reset values without a clock.
    alarm_enable = 1;
    fireAt(0, 2);
    snooze = 1; step();
    check("pre_reset_snooze", {15'd0, snoozing}, 16'h1);
    #2 resetn = 0;
    #1;
    check("rst_mid_alarm", {alm_hrT, alm_hrU, alm_minT, alm_minU}, 16'h0700);
    check("rst_mid_outs", {9'd0, sel, blink, buzzer, snoozing}, 16'h0);
    @(negedge clk); @(negedge clk);
    resetn = 1; step(); step();
    check("post_reset_idle", {14'd0, buzzer, snoozing}, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
- Alarm controller for the clock: holds a user-programmable HH:MM alarm and compares it against the running BCD time.
- Sequences the buzzer through the ring, snooze and auto-off phases.
- Provides the alarm-digit edit mode that mirrors set-time editing: debounced select/increment pulses, one-hot digit selection and a blink strobe for the display.
- Sits beside the time registers; consumes the 1 Hz `inc` strobe and the six time digits.

Parameters:
- RING_SECONDS, 60, sec_tick count before the buzzer auto-stops.
- SNOOZE_SECONDS, 300, sec_tick count spent in snooze before re-ringing.
- CNT_W, 9, phase counter width; must hold max(RING_SECONDS, SNOOZE_SECONDS)-1.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- sec_tick  in  1  one-cycle 1 Hz strobe (the second counter's inc)
- hrT, hrU, minT, minU, secT, secU  in  4 each  current time, BCD
- alarm_enable  in  1  level; alarm armed when high
- set_alarm  in  1  level; alarm edit mode while high
- switch_select  in  1  debounced one-cycle pulse; advance edit digit
- increment  in  1  debounced one-cycle pulse; increment selected digit
- snooze  in  1  debounced one-cycle pulse
- dismiss  in  1  debounced one-cycle pulse
- alm_hrT, alm_hrU, alm_minT, alm_minU  out  4 each  stored alarm, BCD
- sel  out  4  one-hot edit digit: bit0 minU, bit1 minT, bit2 hrU, bit3 hrT; 0 outside SET
- blink  out  1  toggles on sec_tick in SET; 0 otherwise
- buzzer  out  1  high only in RING
- snoozing  out  1  high only in SNOOZE

Behaviour:
- Clock and reset: all state on posedge clk; asynchronous clear on resetn low.
- Reset values:
  - state IDLE
  - alarm 07:00 (alm_hrT=0, alm_hrU=7, alm_minT=0, alm_minU=0)
  - sel=0, blink=0, buzzer=0, snoozing=0
  - cnt=0, eq_d=0
- Match:
  - eq = (hrT,hrU,minT,minU)==alarm AND secT==0 AND secU==0.
  - eq_d is eq registered.
  - fire = eq & ~eq_d & alarm_enable & (state==IDLE).
  - Rising-edge detection guarantees one fire per matching minute.
  - buzzer rises the cycle after eq first becomes true.
- States: IDLE, SET, RING, SNOOZE. Outputs are registered and decoded from state.
  - IDLE:
    - set_alarm -> SET, sel=0001, blink=0.
    - else fire -> RING, cnt=0.
  - SET:
    - On switch_select: sel rotates left (0001->0010->0100->1000->0001).
    - On increment, the selected digit updates:
      - minU: 9->0, otherwise +1.
      - minT: 5->0, otherwise +1.
      - hrU: wraps to 0 after 9 when alm_hrT<2, after 3 when alm_hrT==2.
      - hrT: 2->0, otherwise +1. If the new hrT==2 and alm_hrU>3, alm_hrU is forced to 0 in the same cycle.
    - switch_select and increment in the same cycle: increment applies to the current (pre-rotate) digit.
    - blink toggles on each sec_tick.
    - set_alarm low -> IDLE; sel=0, blink=0.
    - Match ignored in SET.
  - RING:
    - Priority: set_alarm -> SET; dismiss or ~alarm_enable -> IDLE; snooze -> SNOOZE with cnt=0; sec_tick & cnt==RING_SECONDS-1 -> IDLE; sec_tick -> cnt+1.
    - Ring duration is exactly RING_SECONDS ticks.
  - SNOOZE:
    - Priority: set_alarm -> SET; dismiss or ~alarm_enable -> IDLE; sec_tick & cnt==SNOOZE_SECONDS-1 -> RING with cnt=0; sec_tick -> cnt+1.
    - Match ignored in SNOOZE.
- Simultaneous events:
  - dismiss beats snooze.
  - snooze beats expiry on the same sec_tick.
  - set_alarm beats everything.
- Alarm digits change only in SET. Entering SET from RING/SNOOZE drops buzzer/snoozing on the next cycle.
- Time being edited to equal the alarm while IDLE fires normally (edge of eq).
- Reset mid-RING/SNOOZE: returns to IDLE, alarm restored to 07:00.
- Out-of-range time inputs are compared literally; no validation.

Test Plan:
- Reset, enable=1, drive time 06:59:59 then 07:00:00 -> buzzer=1 on the next clk; held 07:00:00 for 10 cycles -> no refire after dismiss.
- RING with RING_SECONDS=4, issue 4 sec_ticks -> buzzer falls after the 4th tick; state IDLE; no re-ring within 07:00:xx.
- RING, pulse snooze -> snoozing=1, buzzer=0; SNOOZE_SECONDS=3 ticks -> buzzer=1 again; snooze+dismiss in the same cycle -> IDLE.
- SET: sel=0001; 12 increments -> alm_minU=2 (wraps after 9); select x2 to hrU, 5 increments -> hrU=2 (7->9->0->2); select to hrT, 2 increments -> hrT=2, hrU=2 kept; release -> alarm 22:02, sel=0.
- SET with alarm 19:xx, increment hrT once -> 29 illegal, so alm_hrT=2, alm_hrU=0.
- alarm_enable=0 at match -> no buzzer; drop alarm_enable mid-RING -> buzzer 0 on the next cycle; assert resetn low mid-SNOOZE -> all outputs at reset values immediately.
